ghost_director: RTL and testbench
=================================

// Module: ghost_director
// PURPOSE
//  Per-frame ghost steering controller. Consumes Pac-Man and ghost positions (the 10-bit X/Y
//  outputs of the motion blocks) and produces a WASD keycode that drives the ghost's motion block.
//  Runs the scatter/chase/frightened mode FSM with frame-count timers and a direction hold to
//  suppress dithering. One instance per ghost, clocked by frame_clk next to the motion blocks.
// PARAMETERS
//  SCATTER_FRAMES  420   frames spent in SCATTER per phase
//  CHASE_FRAMES    1200  frames spent in CHASE per phase
//  FRIGHT_FRAMES   360   frames spent in FRIGHT per power pellet
//  HOLD_FRAMES     8     minimum frames between direction changes (>=1)
//  CORNER_X        620   scatter target X
//  CORNER_Y        20    scatter target Y
//  DEADBAND        2     |dx| and |dy| both <= DEADBAND -> target reached
// PORTS
//  frame_clk      in   1   frame clock (one edge per video frame)
//  Reset          in   1   asynchronous, active-high reset
//  enable         in   1   game running; low forces IDLE
//  power_pellet   in   1   one-frame pulse: Pac-Man ate a power pellet
//  PacX, PacY     in   10  Pac-Man centre position, unsigned pixels
//  GhostX, GhostY in   10  this ghost's centre position, unsigned pixels
//  keycode_out    out  8   8'h04 left, 8'h07 right, 8'h16 down, 8'h1A up, 8'h00 none
//  mode           out  2   00 IDLE, 01 SCATTER, 10 CHASE, 11 FRIGHT
//  fright_active  out  1   1 while mode==FRIGHT (sprite palette select)
// BEHAVIOUR
//  Reset (async, any time incl. mid-FRIGHT): keycode_out=8'h00, mode=IDLE, fright_active=0,
//   phase timer=0, fright timer=0, hold counter=0, saved mode=SCATTER.
//  All outputs registered; inputs sampled at frame_clk edge N are reflected after edge N.
//  FSM:
//   IDLE: keycode_out=00. enable=1 -> SCATTER, phase timer=SCATTER_FRAMES-1.
//   SCATTER: timer decrements per frame; at 0 -> CHASE, timer=CHASE_FRAMES-1.
//   CHASE: timer decrements; at 0 -> SCATTER, timer=SCATTER_FRAMES-1.
//   SCATTER/CHASE + power_pellet -> FRIGHT, saved mode=current, phase timer frozen,
//    fright timer=FRIGHT_FRAMES-1. Pellet outranks a same-frame phase expiry (no phase switch).
//   FRIGHT: fright timer decrements; power_pellet reloads it to FRIGHT_FRAMES-1;
//    at 0 -> saved mode, phase timer resumes from frozen value.
//   enable=0 in any state -> IDLE next edge, keycode_out=00; re-enable restarts at SCATTER.
//  Target: SCATTER=(CORNER_X,CORNER_Y); CHASE and FRIGHT=(PacX,PacY).
//  Decision (11-bit signed): dx={1'b0,TX}-{1'b0,GhostX}; dy={1'b0,TY}-{1'b0,GhostY}.
//   |dx|<=DEADBAND and |dy|<=DEADBAND -> 8'h00.
//   else |dx|>=|dy| (tie -> horizontal): dx>0 -> 8'h07, else 8'h04.
//   else: dy>0 -> 8'h16, else 8'h1A.
//   FRIGHT inverts the result (04<->07, 16<->1A; 00 stays 00).
//  Hold: new decision loaded into keycode_out only when hold counter==0, which reloads
//   HOLD_FRAMES-1; otherwise counter decrements and keycode_out keeps its value.
//   Any mode change zeroes the counter, so the first frame in the new mode commits.
//  No X/Y wrap: position differences span -639..+639, always fit 11 bits signed.
// TESTING
//  1 Reset, enable=1, Ghost=(100,100), Pac=(300,110): mode=01 after 1 edge, keycode 8'h07
//    (target is corner (620,20): dx=520 > |dy|=80).
//  2 Run 420 frames: mode 01->10 at edge 421; Pac=(100,300): keycode 8'h16 on that edge;
//    Pac moves to (300,100) next frame: keycode stays 8'h16 for 7 frames, then 8'h07.
//  3 CHASE, Ghost=(200,200), Pac=(210,200), pulse power_pellet: mode=11, fright_active=1,
//    keycode 8'h04; after 360 frames mode returns to 10 with phase timer unchanged.
//  4 Pellet during FRIGHT at frame 300: FRIGHT extends to 660 frames total; pellet coincident
//    with SCATTER expiry: mode -> 11, then returns to 01 and expires on the next frame.
//  5 Ghost=(320,240), Pac=(322,238) in CHASE -> 8'h00; Pac=(330,240) -> 8'h07;
//    Pac=(330,250) tie -> 8'h07.
//  6 Assert Reset mid-FRIGHT: outputs 00/00/0 immediately; enable=0 in CHASE -> IDLE, keycode 8'h00.

Source files
------------

// File: rtl/ghost_director.sv
// ghost_director
//   Per-frame ghost steering controller. Runs the SCATTER/CHASE/FRIGHT mode
//   machine on frame-count timers, picks a target (scatter corner or Pac-Man),
//   and emits a WASD keycode for the ghost's motion block. A hold counter
//   limits how often the emitted direction may change.
//
// Ports
//   frame_clk      in   1   frame clock, one rising edge per video frame
//   Reset          in   1   asynchronous, active-high reset
//   enable         in   1   game running; low forces IDLE
//   power_pellet   in   1   one-frame pulse: Pac-Man ate a power pellet
//   PacX, PacY     in  10   Pac-Man centre position (unsigned pixels)
//   GhostX, GhostY in  10   this ghost's centre position (unsigned pixels)
//   keycode_out    out  8   04 left, 07 right, 16 down, 1A up, 00 none
//   mode           out  2   00 IDLE, 01 SCATTER, 10 CHASE, 11 FRIGHT
//   fright_active  out  1   high while mode is FRIGHT
module ghost_director #(
    parameter int unsigned SCATTER_FRAMES = 420,
    parameter int unsigned CHASE_FRAMES   = 1200,
    parameter int unsigned FRIGHT_FRAMES  = 360,
    parameter int unsigned HOLD_FRAMES    = 8,
    parameter int unsigned CORNER_X       = 620,
    parameter int unsigned CORNER_Y       = 20,
    parameter int unsigned DEADBAND       = 2
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic       power_pellet,
    input  logic [9:0] PacX,
    input  logic [9:0] PacY,
    input  logic [9:0] GhostX,
    input  logic [9:0] GhostY,
    output logic [7:0] keycode_out,
    output logic [1:0] mode,
    output logic       fright_active
);

    localparam int unsigned PHASE_MAX = (SCATTER_FRAMES > CHASE_FRAMES) ? SCATTER_FRAMES : CHASE_FRAMES;
    localparam int unsigned PW = (PHASE_MAX     > 1) ? $clog2(PHASE_MAX)     : 1;
    localparam int unsigned FW = (FRIGHT_FRAMES > 1) ? $clog2(FRIGHT_FRAMES) : 1;
    localparam int unsigned HW = (HOLD_FRAMES   > 1) ? $clog2(HOLD_FRAMES)   : 1;

    localparam logic [PW-1:0] SCATTER_RELOAD = PW'(SCATTER_FRAMES - 1);
    localparam logic [PW-1:0] CHASE_RELOAD   = PW'(CHASE_FRAMES - 1);
    localparam logic [FW-1:0] FRIGHT_RELOAD  = FW'(FRIGHT_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_RELOAD    = HW'(HOLD_FRAMES - 1);

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SCATTER = 2'b01,
        ST_CHASE   = 2'b10,
        ST_FRIGHT  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    state_t        saved_q, saved_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [FW-1:0] fright_q, fright_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    key_q, key_d;
    logic          fright_act_q, fright_act_d;

    // Steering decision inputs
    logic [9:0]  tx, ty;
    logic [10:0] dx, dy;
    logic [10:0] adx, ady;
    logic        in_deadband;
    logic [7:0]  raw_key, steer_key;

    // ---------------- Mode FSM: next state and timers ----------------
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        phase_d  = phase_q;
        fright_d = fright_q;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SCATTER;
                    phase_d = SCATTER_RELOAD;
                end
                ST_SCATTER, ST_CHASE: begin
                    // Pellet wins over a same-frame phase expiry; phase timer stays frozen.
                    if (power_pellet) begin
                        state_d  = ST_FRIGHT;
                        saved_d  = state_q;
                        fright_d = FRIGHT_RELOAD;
                    end else if (phase_q == '0) begin
                        if (state_q == ST_SCATTER) begin
                            state_d = ST_CHASE;
                            phase_d = CHASE_RELOAD;
                        end else begin
                            state_d = ST_SCATTER;
                            phase_d = SCATTER_RELOAD;
                        end
                    end else begin
                        phase_d = phase_q - 1'b1;
                    end
                end
                ST_FRIGHT: begin
                    if (power_pellet) begin
                        fright_d = FRIGHT_RELOAD;
                    end else if (fright_q == '0) begin
                        state_d = saved_q;
                    end else begin
                        fright_d = fright_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- Steering decision for the upcoming mode ----------------
    always_comb begin
        if (state_d == ST_SCATTER) begin
            tx = 10'(CORNER_X);
            ty = 10'(CORNER_Y);
        end else begin
            tx = PacX;
            ty = PacY;
        end

        // Positions are below 640, so the 11-bit differences never overflow.
        dx  = {1'b0, tx} - {1'b0, GhostX};
        dy  = {1'b0, ty} - {1'b0, GhostY};
        adx = dx[10] ? (~dx + 11'd1) : dx;
        ady = dy[10] ? (~dy + 11'd1) : dy;

        in_deadband = (adx <= 11'(DEADBAND)) && (ady <= 11'(DEADBAND));

        raw_key = KEY_NONE;
        if (!in_deadband) begin
            if (adx >= ady) begin
                raw_key = (!dx[10] && (dx != '0)) ? KEY_RIGHT : KEY_LEFT;
            end else begin
                raw_key = (!dy[10] && (dy != '0)) ? KEY_DOWN : KEY_UP;
            end
        end

        steer_key = raw_key;
        if (state_d == ST_FRIGHT) begin
            unique case (raw_key)
                KEY_LEFT:  steer_key = KEY_RIGHT;
                KEY_RIGHT: steer_key = KEY_LEFT;
                KEY_DOWN:  steer_key = KEY_UP;
                KEY_UP:    steer_key = KEY_DOWN;
                default:   steer_key = KEY_NONE;
            endcase
        end
    end

    // ---------------- Direction hold ----------------
    always_comb begin
        key_d        = key_q;
        hold_d       = hold_q;
        fright_act_d = (state_d == ST_FRIGHT);

        if (state_d == ST_IDLE) begin
            key_d  = KEY_NONE;
            hold_d = '0;
        end else if ((state_d != state_q) || (hold_q == '0)) begin
            // A mode change behaves as if the counter were zero: commit immediately.
            key_d  = steer_key;
            hold_d = HOLD_RELOAD;
        end else begin
            hold_d = hold_q - 1'b1;
        end
    end

    // ---------------- Registers ----------------
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            saved_q      <= ST_SCATTER;
            phase_q      <= '0;
            fright_q     <= '0;
            hold_q       <= '0;
            key_q        <= KEY_NONE;
            fright_act_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            phase_q      <= phase_d;
            fright_q     <= fright_d;
            hold_q       <= hold_d;
            key_q        <= key_d;
            fright_act_q <= fright_act_d;
        end
    end

    assign keycode_out   = key_q;
    assign mode          = state_q;
    assign fright_active = fright_act_q;

endmodule

// File: tb/tb_ghost_director.sv
// tb_ghost_director
//   Directed bench for ghost_director: reset, mode timing, pellet handling,
//   direction hold and steering decisions, with hand-computed expectations.
module tb_ghost_director;

    logic       frame_clk;
    logic       Reset;
    logic       enable;
    logic       power_pellet;
    logic [9:0] PacX, PacY, GhostX, GhostY;
    logic [7:0] keycode_out;
    logic [1:0] mode;
    logic       fright_active;

    int unsigned checks_n;
    int unsigned errors_n;

    ghost_director #(
        .SCATTER_FRAMES (420),
        .CHASE_FRAMES   (1200),
        .FRIGHT_FRAMES  (360),
        .HOLD_FRAMES    (8),
        .CORNER_X       (620),
        .CORNER_Y       (20),
        .DEADBAND       (2)
    ) dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .enable        (enable),
        .power_pellet  (power_pellet),
        .PacX          (PacX),
        .PacY          (PacY),
        .GhostX        (GhostX),
        .GhostY        (GhostY),
        .keycode_out   (keycode_out),
        .mode          (mode),
        .fright_active (fright_active)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks_n++;
        if (actual !== expected) begin
            errors_n++;
            $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic set_pac(input int unsigned x, input int unsigned y);
        PacX = 10'(x);
        PacY = 10'(y);
    endtask

    // Steering vectors in CHASE, ghost fixed at (320,240)
    int unsigned vec_px [7] = '{322, 330, 300, 320, 330, 320, 318};
    int unsigned vec_py [7] = '{238, 240, 240, 260, 250, 200, 243};
    logic [7:0]  vec_key[7] = '{8'h00, 8'h07, 8'h04, 8'h16, 8'h07, 8'h1A, 8'h16};

    initial begin
        checks_n     = 0;
        errors_n     = 0;
        Reset        = 1'b0;
        enable       = 1'b0;
        power_pellet = 1'b0;
        GhostX       = 10'd100;
        GhostY       = 10'd100;
        set_pac(300, 110);

        // Reset before any clock edge
        #2 Reset = 1'b1;
        #1;
        check("rst_mode", 8'(mode), 8'h00);
        check("rst_key", keycode_out, 8'h00);
        check("rst_fright", 8'(fright_active), 8'h00);
        Reset  = 1'b0;
        enable = 1'b1;

        // Edge 1: SCATTER toward corner (620,20)
        step();
        check("t1_mode", 8'(mode), 8'h01);
        check("t1_key", keycode_out, 8'h07);
        check("t1_fright", 8'(fright_active), 8'h00);

        // Edges 2..420 remain SCATTER; edge 421 enters CHASE
        run(419);
        check("t2_mode_420", 8'(mode), 8'h01);
        set_pac(100, 300);
        step();
        check("t2_mode_421", 8'(mode), 8'h10 >> 3);
        check("t2_key_421", keycode_out, 8'h16);
        set_pac(300, 100);
        for (int unsigned i = 0; i < 7; i++) begin
            step();
            check("t2_hold", keycode_out, 8'h16);
        end
        step();
        check("t2_key_429", keycode_out, 8'h07);

        // Edge 430: pellet in CHASE
        GhostX = 10'd200;
        GhostY = 10'd200;
        set_pac(210, 200);
        power_pellet = 1'b1;
        step();
        power_pellet = 1'b0;
        check("t3_mode", 8'(mode), 8'h03);
        check("t3_fright", 8'(fright_active), 8'h01);
        check("t3_key", keycode_out, 8'h04);
        run(358);
        step();
        check("t3_mode_789", 8'(mode), 8'h03);
        step();
        check("t3_mode_790", 8'(mode), 8'h02);
        check("t3_fright_790", 8'(fright_active), 8'h00);
        check("t3_key_790", keycode_out, 8'h07);

        // Edges 791..846: steering vectors, 8 frames each so a commit always occurs
        GhostX = 10'd320;
        GhostY = 10'd240;
        for (int unsigned v = 0; v < 7; v++) begin
            set_pac(vec_px[v], vec_py[v]);
            run(8);
            check($sformatf("t5_vec%0d", v), keycode_out, vec_key[v]);
        end

        // Edge 847: pellet again; last decision (down) is inverted to up
        power_pellet = 1'b1;
        step();
        power_pellet = 1'b0;
        check("t4_mode_847", 8'(mode), 8'h03);
        check("t4_key_847", keycode_out, 8'h1A);
        run(299);
        power_pellet = 1'b1;
        step();
        power_pellet = 1'b0;
        check("t4_mode_1147", 8'(mode), 8'h03);
        run(59);
        step();
        check("t4_mode_1207", 8'(mode), 8'h03);
        run(298);
        step();
        check("t4_mode_1506", 8'(mode), 8'h03);
        step();
        check("t4_mode_1507", 8'(mode), 8'h02);

        // Frozen CHASE timer (1135) resumes: last CHASE frame 2642, SCATTER at 2643
        run(1134);
        step();
        check("t4_mode_2642", 8'(mode), 8'h02);
        step();
        check("t4_mode_2643", 8'(mode), 8'h01);

        // SCATTER expiry at 3063 coincides with a pellet
        run(418);
        step();
        check("t4_mode_3062", 8'(mode), 8'h01);
        power_pellet = 1'b1;
        step();
        power_pellet = 1'b0;
        check("t4_mode_3063", 8'(mode), 8'h03);
        run(358);
        step();
        check("t4_mode_3422", 8'(mode), 8'h03);
        step();
        check("t4_mode_3423", 8'(mode), 8'h01);
        step();
        check("t4_mode_3424", 8'(mode), 8'h02);

        // Disable in CHASE
        enable = 1'b0;
        step();
        check("t6_idle_mode", 8'(mode), 8'h00);
        check("t6_idle_key", keycode_out, 8'h00);
        enable = 1'b1;
        step();
        check("t6_reen_mode", 8'(mode), 8'h01);

        // Asynchronous reset mid-FRIGHT
        power_pellet = 1'b1;
        step();
        power_pellet = 1'b0;
        check("t6_fr_mode", 8'(mode), 8'h03);
        check("t6_fr_active", 8'(fright_active), 8'h01);
        run(5);
        #2 Reset = 1'b1;
        #1;
        check("t6_rst_mode", 8'(mode), 8'h00);
        check("t6_rst_key", keycode_out, 8'h00);
        check("t6_rst_fright", 8'(fright_active), 8'h00);
        step();
        check("t6_rst_hold", 8'(mode), 8'h00);
        Reset = 1'b0;
        step();
        check("t6_after_rst", 8'(mode), 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule
